// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: walks the AES-128 key schedule backwards, one round key per handshake
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start, key_in   load the round-NUM_ROUNDS key and begin (IDLE only)
//   abort           synchronous return to IDLE, beats everything but rst_n
//   out_ready       consumer accepts round_key this cycle
//   out_valid       round_key/round_idx valid
//   round_key       current round key {w0,w1,w2,w3} = [127:96]..[31:0]
//   round_idx       round number of round_key
//   last            out_valid & (round_idx == 0)
//   busy            state != IDLE

// aes_sbox: forward AES byte substitution (GF(2^8) inverse followed by the affine map)
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p, t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse, and maps 0 to 0 as the sbox needs
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction
  logic [7:0] v;
  assign v = ginv(a);
  assign y = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
endmodule

module aes_inv_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         abort,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         last,
  output logic         busy
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;
  logic [127:0] key_reg;
  logic [3:0] idx;
  logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, rot, sub;
  logic [7:0] rcon;
  assign {w0, w1, w2, w3} = key_reg;
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign rot = {p3[23:0], p3[31:24]};
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sb
      aes_sbox u_sbox (.a(rot[8*g +: 8]), .y(sub[8*g +: 8]));
    end
  endgenerate
  always_comb begin
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end
  assign p0 = w0 ^ sub ^ {rcon, 24'h0};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_reg <= '0;
      idx     <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (start) begin
        key_reg <= key_in;
        idx     <= 4'(NUM_ROUNDS);
        state   <= EMIT;
      end
    end else if (out_ready) begin
      if (idx == 4'd0) begin
        state <= IDLE;
      end else begin
        key_reg <= {p0, p1, p2, p3};
        idx     <= idx - 4'd1;
      end
    end
  end
  assign out_valid = state == EMIT;
  assign busy      = state != IDLE;
  assign round_key = key_reg;
  assign round_idx = idx;
  assign last      = out_valid & (idx == 4'd0);
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb_aes_inv_key_schedule: directed checks of the inverse key schedule against FIPS-197 round keys
module tb_aes_inv_key_schedule;
  logic clk = 0, rst_n = 0;
  logic start = 0, abort = 0, out_ready = 0;
  logic [127:0] key_in = '0;
  logic out_valid, last, busy;
  logic [127:0] round_key;
  logic [3:0] round_idx;
  logic start1 = 0, ready1 = 0;
  logic [127:0] key1 = '0;
  logic valid1, last1, busy1;
  logic [127:0] rkey1;
  logic [3:0] ridx1;
  int total = 0, bad = 0;
  logic [127:0] fk [0:10];

  always #5 clk = ~clk;

  aes_inv_key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .round_key(round_key),
    .round_idx(round_idx), .last(last), .busy(busy)
  );

  aes_inv_key_schedule #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .key_in(key1), .abort(1'b0),
    .out_ready(ready1), .out_valid(valid1), .round_key(rkey1),
    .round_idx(ridx1), .last(last1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    key_in = fk[10];
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // consumes the whole sequence; bp toggles out_ready, inject pulses start with another key at idx 5
  task automatic run_full(input bit bp, input bit inject);
    int e;
    int cyc;
    pulse_start();
    e = 10;
    cyc = 0;
    while (e >= 0 && cyc < 300) begin
      chk("valid", 128'(out_valid), 128'd1);
      chk("idx", 128'(round_idx), 128'(e));
      chk("key", round_key, fk[e]);
      chk("last", 128'(last), 128'(e == 0));
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start = inject && e == 5;
      key_in = inject && e == 5 ? 128'h0123456789abcdef0123456789abcdef : fk[10];
      if (out_ready) e--;
      cyc++;
      @(negedge clk);
      start = 0;
    end
    chk("seq_done", 128'(e), 128'hffffffff_ffffffff_ffffffff_ffffffff);
    out_ready = 0;
    chk("end_valid", 128'(out_valid), 128'd0);
    chk("end_busy", 128'(busy), 128'd0);
    chk("end_last", 128'(last), 128'd0);
  endtask

  initial begin
    int cyc;
    fk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    #2;
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_last", 128'(last), 128'd0);
    chk("rst_key", round_key, 128'd0);
    chk("rst_idx", 128'(round_idx), 128'd0);
    @(negedge clk);
    rst_n = 1;
    run_full(0, 0);
    run_full(1, 0);
    run_full(0, 1);
    // abort at idx 7 with out_ready high in the same cycle
    pulse_start();
    out_ready = 1;
    cyc = 0;
    while (!(out_valid && round_idx == 4'd7) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach7", 128'(round_idx), 128'd7);
    abort = 1;
    @(negedge clk);
    abort = 0;
    out_ready = 0;
    chk("abort_valid", 128'(out_valid), 128'd0);
    chk("abort_busy", 128'(busy), 128'd0);
    repeat (2) @(negedge clk);
    chk("abort_idle", 128'(out_valid), 128'd0);
    run_full(0, 0);
    // asynchronous reset between edges while emitting
    pulse_start();
    out_ready = 1;
    repeat (3) @(negedge clk);
    out_ready = 0;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_key", round_key, 128'd0);
    chk("arst_idx", 128'(round_idx), 128'd0);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    repeat (3) @(negedge clk);
    chk("post_valid", 128'(out_valid), 128'd0);
    chk("post_key", round_key, 128'd0);
    chk("post_idx", 128'(round_idx), 128'd0);
    out_ready = 0;
    run_full(0, 0);
    // NUM_ROUNDS = 1 instance
    @(negedge clk);
    key1 = fk[1];
    start1 = 1;
    ready1 = 1;
    @(negedge clk);
    start1 = 0;
    chk("n1_valid1", 128'(valid1), 128'd1);
    chk("n1_idx1", 128'(ridx1), 128'd1);
    chk("n1_key1", rkey1, fk[1]);
    chk("n1_last1", 128'(last1), 128'd0);
    @(negedge clk);
    chk("n1_valid0", 128'(valid1), 128'd1);
    chk("n1_idx0", 128'(ridx1), 128'd0);
    chk("n1_key0", rkey1, fk[0]);
    chk("n1_last0", 128'(last1), 128'd1);
    @(negedge clk);
    chk("n1_end", 128'(valid1), 128'd0);
    chk("n1_busy", 128'(busy1), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
